// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
package intr_pkg;

    localparam int unsigned VT_W    = 5;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SR_W    = 8;
    localparam int unsigned DEPTH_W = 3;

    localparam logic [VT_W-1:0] VT_NONE = 5'd0;
    localparam logic [VT_W-1:0] VT_NMI  = 5'd1;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_PC,
        PUSH_SR,
        FETCH,
        JUMP
    } state_t;

    // Byte address of a vector table entry (one 32-bit word per vector).
    function automatic logic [ADDR_W-1:0] vec_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [VT_W-1:0]   vt);
        return base + {{(ADDR_W-VT_W-2){1'b0}}, vt, 2'b00};
    endfunction

endpackage

// File: rtl/intr_ack_seq_if.sv
// Memory request/acknowledge bus used by the interrupt sequencer.
interface intr_ack_seq_if;
    import intr_pkg::*;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/intr_ack_seq.sv
// Interrupt acknowledge sequencer: pushes PC and SR, fetches the vector,
// redirects the CPU and tracks nesting depth / interrupt mask.
// Optional feature macro: INTR_NEST_EN (software unmask inside handlers).
module intr_ack_seq
    import intr_pkg::*;
#(
    parameter logic [ADDR_W-1:0] VEC_BASE  = 32'h0000_0000,
    parameter int unsigned       MAX_DEPTH = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                intr_ev,
    input  logic [VT_W-1:0]     vt_no,
    input  logic                insn_boundary,
    input  logic [ADDR_W-1:0]   cur_pc,
    input  logic [SR_W-1:0]     cur_sr,
    input  logic [ADDR_W-1:0]   sp,
    input  logic                rte,
    input  logic                i_bit_clr,
    intr_ack_seq_if.master      bus,
    output logic                cpu_stall,
    output logic                pc_load,
    output logic [ADDR_W-1:0]   pc_new,
    output logic                sp_load,
    output logic [ADDR_W-1:0]   sp_new,
    output logic                i_bit,
    output logic                intr_ack,
    output logic [VT_W-1:0]     ack_vt_no,
    output logic [DEPTH_W-1:0]  depth
);

    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

    state_t              state_q, state_d;
    logic [VT_W-1:0]     vt_q, vt_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic [DATA_W-1:0]   vec_q, vec_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                i_bit_q, i_bit_d;

    logic                clr_allowed;
    logic                mask_depth_ok;
    logic                accept;

`ifdef INTR_NEST_EN
    assign clr_allowed   = 1'b1;
    assign mask_depth_ok = 1'b1;
`else
    // i_bit resets to 1, so the boot-time unmask at depth 0 is still honoured;
    // only unmasking from inside a handler is dropped.
    assign clr_allowed   = (depth_q == '0);
    assign mask_depth_ok = (depth_q == '0);
`endif

    assign accept = intr_ev && insn_boundary && (vt_no != VT_NONE) &&
                    (depth_q < MAX_D) &&
                    ((vt_no == VT_NMI) || (!i_bit_q && mask_depth_ok));

    assign ack_vt_no = vt_q;
    assign i_bit     = i_bit_q;
    assign depth     = depth_q;

    // State and context registers; reset forces IDLE with the mask set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vt_q    <= VT_NONE;
            pc_q    <= '0;
            sr_q    <= '0;
            sp_q    <= '0;
            vec_q   <= '0;
            depth_q <= '0;
            i_bit_q <= 1'b1;
        end else begin
            state_q <= state_d;
            vt_q    <= vt_d;
            pc_q    <= pc_d;
            sr_q    <= sr_d;
            sp_q    <= sp_d;
            vec_q   <= vec_d;
            depth_q <= depth_d;
            i_bit_q <= i_bit_d;
        end
    end

    // Next-state, bus request and CPU control outputs.
    always_comb begin
        state_d       = state_q;
        vt_d          = vt_q;
        pc_d          = pc_q;
        sr_d          = sr_q;
        sp_d          = sp_q;
        vec_d         = vec_q;
        depth_d       = depth_q;
        i_bit_d       = i_bit_q;
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        cpu_stall     = 1'b0;
        pc_load       = 1'b0;
        pc_new        = '0;
        sp_load       = 1'b0;
        sp_new        = '0;
        intr_ack      = 1'b0;

        case (state_q)
            IDLE: begin
                // rte takes priority over a coincident acceptance.
                if (rte && (depth_q != '0)) begin
                    depth_d = depth_q - 3'd1;
                    if (depth_q == 3'd1) begin
                        i_bit_d = 1'b0;
                    end
                end else if (accept) begin
                    vt_d    = vt_no;
                    pc_d    = cur_pc;
                    sr_d    = cur_sr;
                    sp_d    = sp;
                    state_d = PUSH_PC;
                end else if (i_bit_clr && clr_allowed) begin
                    i_bit_d = 1'b0;
                end
            end
            PUSH_PC: begin
                cpu_stall     = 1'b1;
                bus.bus_req   = 1'b1;
                bus.bus_we    = 1'b1;
                bus.bus_addr  = sp_q - 32'd4;
                bus.bus_wdata = pc_q;
                if (bus.bus_ack) begin
                    state_d = PUSH_SR;
                end
            end
            PUSH_SR: begin
                cpu_stall     = 1'b1;
                bus.bus_req   = 1'b1;
                bus.bus_we    = 1'b1;
                bus.bus_addr  = sp_q - 32'd8;
                bus.bus_wdata = {24'b0, sr_q};
                if (bus.bus_ack) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                cpu_stall    = 1'b1;
                bus.bus_req  = 1'b1;
                bus.bus_addr = vec_addr(VEC_BASE, vt_q);
                if (bus.bus_ack) begin
                    vec_d   = bus.bus_rdata;
                    state_d = JUMP;
                end
            end
            JUMP: begin
                cpu_stall = 1'b1;
                pc_load   = 1'b1;
                pc_new    = vec_q;
                sp_load   = 1'b1;
                sp_new    = sp_q - 32'd8;
                intr_ack  = 1'b1;
                depth_d   = depth_q + 3'd1;
                i_bit_d   = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
